// File: rtl/alu_seq_ctrl.sv
// Sequencing front-end for a 16-bit combinational ALU: runs narrow ops in one pass and
// 32-bit add/sub/and/or in two passes plus an optional carry-correction pass.
module alu_seq_ctrl (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [2:0]  ReqOp,
    input  logic        ReqWide,
    input  logic [31:0] ReqA,
    input  logic [31:0] ReqB,
    output logic [15:0] AluA,
    output logic [15:0] AluB,
    output logic        AluBNegate,
    output logic [1:0]  AluOp,
    input  logic [15:0] AluResult,
    input  logic        AluZero,
    input  logic        AluOverflow,
    input  logic        AluCarryOut,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] RspResult,
    output logic        RspZero,
    output logic        RspOverflow,
    output logic        RspCarry
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_FIX  = 3'd3,
        ST_RSP  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        K_AND = 3'd0,
        K_OR  = 3'd1,
        K_ADD = 3'd2,
        K_SUB = 3'd3,
        K_SLT = 3'd4
    } kind_e;

    function automatic kind_e decode_op(input logic [2:0] op);
        kind_e k;
        case (op)
            3'b001:  k = K_OR;
            3'b010:  k = K_ADD;
            3'b110:  k = K_SUB;
            3'b111:  k = K_SLT;
            default: k = K_AND;
        endcase
        return k;
    endfunction

    function automatic logic [1:0] alu_op_of(input kind_e k);
        logic [1:0] o;
        case (k)
            K_OR:    o = 2'b01;
            K_ADD:   o = 2'b10;
            K_SUB:   o = 2'b10;
            K_SLT:   o = 2'b11;
            default: o = 2'b00;
        endcase
        return o;
    endfunction

    function automatic logic bneg_of(input kind_e k);
        logic b;
        case (k)
            K_SUB:   b = 1'b1;
            K_SLT:   b = 1'b1;
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic        wide_q, wide_d;
    logic [15:0] a_hi_q, a_hi_d;
    logic [15:0] b_hi_q, b_hi_d;
    logic [15:0] res_lo_q, res_lo_d;
    logic        c_lo_q, c_lo_d;
    logic        c_hi_q, c_hi_d;
    logic [15:0] alu_a_q, alu_a_d;
    logic [15:0] alu_b_q, alu_b_d;
    logic        alu_bneg_q, alu_bneg_d;
    logic [1:0]  alu_op_q, alu_op_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        rsp_zero_q, rsp_zero_d;
    logic        rsp_ovf_q, rsp_ovf_d;
    logic        rsp_carry_q, rsp_carry_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        req_ready_q, req_ready_d;

    kind_e       req_kind_s;
    logic        fin_carry_s;
    logic [31:0] wide_result_s;
    logic        wide_zero_s;
    logic        wide_ovf_s;
    logic        wide_carry_s;

    // Decode the incoming opcode for the accept cycle.
    always_comb begin
        req_kind_s = decode_op(ReqOp);
    end

    // Final upper-half result and flags of a wide op, valid in the last HI or FIX pass.
    always_comb begin
        fin_carry_s   = AluCarryOut;
        wide_ovf_s    = 1'b0;
        wide_carry_s  = 1'b0;
        wide_result_s = {AluResult, res_lo_q};
        wide_zero_s   = (wide_result_s == 32'h0000_0000);
        if (state_q == ST_FIX) begin
            // The correction pass either propagates a carry (ADD) or cancels a borrow (SUB).
            if (kind_q == K_ADD) begin
                fin_carry_s = c_hi_q | AluCarryOut;
            end else begin
                fin_carry_s = c_hi_q & AluCarryOut;
            end
        end else begin
            fin_carry_s = AluCarryOut;
        end
        case (kind_q)
            K_ADD: begin
                wide_ovf_s   = ~(a_hi_q[15] ^ b_hi_q[15]) & (a_hi_q[15] ^ AluResult[15]);
                wide_carry_s = fin_carry_s;
            end
            K_SUB: begin
                wide_ovf_s   = (a_hi_q[15] ^ b_hi_q[15]) & (a_hi_q[15] ^ AluResult[15]);
                wide_carry_s = fin_carry_s;
            end
            default: begin
                wide_ovf_s   = 1'b0;
                wide_carry_s = 1'b0;
            end
        endcase
    end

    // Next-state and next-output logic of the pass sequencer.
    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        wide_d       = wide_q;
        a_hi_d       = a_hi_q;
        b_hi_d       = b_hi_q;
        res_lo_d     = res_lo_q;
        c_lo_d       = c_lo_q;
        c_hi_d       = c_hi_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_bneg_d   = alu_bneg_q;
        alu_op_d     = alu_op_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_carry_d  = rsp_carry_q;

        case (state_q)
            ST_IDLE: begin
                if (ReqValid) begin
                    kind_d     = req_kind_s;
                    wide_d     = ReqWide & (req_kind_s != K_SLT);
                    a_hi_d     = ReqA[31:16];
                    b_hi_d     = ReqB[31:16];
                    alu_a_d    = ReqA[15:0];
                    alu_b_d    = ReqB[15:0];
                    alu_bneg_d = bneg_of(req_kind_s);
                    alu_op_d   = alu_op_of(req_kind_s);
                    state_d    = ST_LO;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_LO: begin
                res_lo_d = AluResult;
                c_lo_d   = AluCarryOut;
                if (wide_q) begin
                    alu_a_d = a_hi_q;
                    alu_b_d = b_hi_q;
                    state_d = ST_HI;
                end else begin
                    rsp_result_d = {16'h0000, AluResult};
                    rsp_zero_d   = AluZero;
                    rsp_ovf_d    = AluOverflow;
                    rsp_carry_d  = AluCarryOut;
                    state_d      = ST_RSP;
                end
            end
            ST_HI: begin
                c_hi_d = AluCarryOut;
                // Upper half was computed with carry-in = BNegate; fix it when the lower carry disagrees.
                if ((kind_q == K_ADD) && c_lo_q) begin
                    alu_a_d    = AluResult;
                    alu_b_d    = 16'h0001;
                    alu_bneg_d = 1'b0;
                    alu_op_d   = 2'b10;
                    state_d    = ST_FIX;
                end else if ((kind_q == K_SUB) && !c_lo_q) begin
                    alu_a_d    = AluResult;
                    alu_b_d    = 16'hFFFF;
                    alu_bneg_d = 1'b0;
                    alu_op_d   = 2'b10;
                    state_d    = ST_FIX;
                end else begin
                    rsp_result_d = wide_result_s;
                    rsp_zero_d   = wide_zero_s;
                    rsp_ovf_d    = wide_ovf_s;
                    rsp_carry_d  = wide_carry_s;
                    state_d      = ST_RSP;
                end
            end
            ST_FIX: begin
                rsp_result_d = wide_result_s;
                rsp_zero_d   = wide_zero_s;
                rsp_ovf_d    = wide_ovf_s;
                rsp_carry_d  = wide_carry_s;
                state_d      = ST_RSP;
            end
            ST_RSP: begin
                if (RspReady) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RSP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RSP);
    end

    // State, operand, pass-result and output registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_IDLE;
            kind_q       <= K_AND;
            wide_q       <= 1'b0;
            a_hi_q       <= 16'h0000;
            b_hi_q       <= 16'h0000;
            res_lo_q     <= 16'h0000;
            c_lo_q       <= 1'b0;
            c_hi_q       <= 1'b0;
            alu_a_q      <= 16'h0000;
            alu_b_q      <= 16'h0000;
            alu_bneg_q   <= 1'b0;
            alu_op_q     <= 2'b00;
            rsp_result_q <= 32'h0000_0000;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_carry_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            wide_q       <= wide_d;
            a_hi_q       <= a_hi_d;
            b_hi_q       <= b_hi_d;
            res_lo_q     <= res_lo_d;
            c_lo_q       <= c_lo_d;
            c_hi_q       <= c_hi_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_bneg_q   <= alu_bneg_d;
            alu_op_q     <= alu_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_valid_q  <= rsp_valid_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign ReqReady    = req_ready_q;
    assign AluA        = alu_a_q;
    assign AluB        = alu_b_q;
    assign AluBNegate  = alu_bneg_q;
    assign AluOp       = alu_op_q;
    assign RspValid    = rsp_valid_q;
    assign RspResult   = rsp_result_q;
    assign RspZero     = rsp_zero_q;
    assign RspOverflow = rsp_ovf_q;
    assign RspCarry    = rsp_carry_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: models ALU16 behind the controller and scores responses
// against a 32-bit reference through an expectation queue.
module tb_alu_seq_ctrl;

    logic        Clock;
    logic        Reset_n;
    logic        ReqValid;
    logic        ReqReady;
    logic [2:0]  ReqOp;
    logic        ReqWide;
    logic [31:0] ReqA;
    logic [31:0] ReqB;
    logic [15:0] AluA;
    logic [15:0] AluB;
    logic        AluBNegate;
    logic [1:0]  AluOp;
    logic [15:0] AluResult;
    logic        AluZero;
    logic        AluOverflow;
    logic        AluCarryOut;
    logic        RspValid;
    logic        RspReady;
    logic [31:0] RspResult;
    logic        RspZero;
    logic        RspOverflow;
    logic        RspCarry;

    alu_seq_ctrl dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .ReqValid    (ReqValid),
        .ReqReady    (ReqReady),
        .ReqOp       (ReqOp),
        .ReqWide     (ReqWide),
        .ReqA        (ReqA),
        .ReqB        (ReqB),
        .AluA        (AluA),
        .AluB        (AluB),
        .AluBNegate  (AluBNegate),
        .AluOp       (AluOp),
        .AluResult   (AluResult),
        .AluZero     (AluZero),
        .AluOverflow (AluOverflow),
        .AluCarryOut (AluCarryOut),
        .RspValid    (RspValid),
        .RspReady    (RspReady),
        .RspResult   (RspResult),
        .RspZero     (RspZero),
        .RspOverflow (RspOverflow),
        .RspCarry    (RspCarry)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // ALU16 model: B optionally inverted, carry-in tied to BNegate.
    logic [15:0] m_beff;
    logic [16:0] m_sum;
    logic        m_ovf;
    always_comb begin
        m_beff = AluB ^ {16{AluBNegate}};
        m_sum  = {1'b0, AluA} + {1'b0, m_beff} + {16'h0000, AluBNegate};
        m_ovf  = (AluA[15] == m_beff[15]) && (m_sum[15] != AluA[15]);
        case (AluOp)
            2'b00:   AluResult = AluA & m_beff;
            2'b01:   AluResult = AluA | m_beff;
            2'b10:   AluResult = m_sum[15:0];
            default: AluResult = {15'h0000, m_sum[15] ^ m_ovf};
        endcase
        AluZero     = (AluResult == 16'h0000);
        AluOverflow = m_ovf;
        AluCarryOut = m_sum[16];
    end

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        carry;
        logic [3:0]  lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_model(input logic [2:0] op, input logic wide,
                                       input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic        is_or, is_add, is_sub, is_slt, lo_c;
        logic [15:0] a16, b16;
        logic [16:0] s17;
        logic [32:0] s33;
        is_or  = (op == 3'b001);
        is_add = (op == 3'b010);
        is_sub = (op == 3'b110);
        is_slt = (op == 3'b111);
        e      = '0;
        if (!wide || is_slt) begin
            a16 = a[15:0];
            b16 = b[15:0];
            if (is_sub || is_slt) begin
                s17   = {1'b0, a16} + {1'b0, ~b16} + 17'd1;
                e.ovf = (a16[15] != b16[15]) && (s17[15] != a16[15]);
            end else begin
                s17   = {1'b0, a16} + {1'b0, b16};
                e.ovf = (a16[15] == b16[15]) && (s17[15] != a16[15]);
            end
            e.carry = s17[16];
            if (is_slt)               e.res = {31'd0, ($signed(a16) < $signed(b16))};
            else if (is_or)           e.res = {16'h0000, a16 | b16};
            else if (is_add || is_sub) e.res = {16'h0000, s17[15:0]};
            else                      e.res = {16'h0000, a16 & b16};
            e.lat = 4'd2;
        end else begin
            if (is_add) begin
                s33     = {1'b0, a} + {1'b0, b};
                e.res   = s33[31:0];
                e.carry = s33[32];
                e.ovf   = (a[31] == b[31]) && (e.res[31] != a[31]);
                lo_c    = ({1'b0, a[15:0]} + {1'b0, b[15:0]}) > 17'h0FFFF;
                e.lat   = lo_c ? 4'd4 : 4'd3;
            end else if (is_sub) begin
                s33     = {1'b0, a} + {1'b0, ~b} + 33'd1;
                e.res   = s33[31:0];
                e.carry = s33[32];
                e.ovf   = (a[31] != b[31]) && (e.res[31] != a[31]);
                e.lat   = (a[15:0] < b[15:0]) ? 4'd4 : 4'd3;
            end else begin
                e.res   = is_or ? (a | b) : (a & b);
                e.lat   = 4'd3;
            end
        end
        e.zero = (e.res == 32'h0000_0000);
        return e;
    endfunction

    // Drive a request at #1 after a rising edge and wait for the accepting edge.
    task automatic accept_req(input logic [2:0] op, input logic wide,
                              input logic [31:0] a, input logic [31:0] b, output bit ok);
        int cyc;
        ReqValid = 1'b1;
        ReqOp    = op;
        ReqWide  = wide;
        ReqA     = a;
        ReqB     = b;
        exp_q.push_back(ref_model(op, wide, a, b));
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < 20) begin
            if (ReqReady) ok = 1'b1;
            @(posedge Clock);
            #1;
            cyc++;
        end
        ReqValid = 1'b0;
        ReqA     = $urandom;
        ReqB     = $urandom;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_req(input string tag, input logic [2:0] op, input logic wide,
                           input logic [31:0] a, input logic [31:0] b, input int hold);
        bit          ok;
        int          lat;
        exp_t        e;
        logic [31:0] snap;
        accept_req(op, wide, a, b, ok);
        lat = 1;
        check({tag, "_busy"}, {31'd0, ReqReady}, 32'd0);
        while (!RspValid && lat < 10) begin
            @(posedge Clock);
            #1;
            lat++;
            if (!RspValid) check({tag, "_busy_wait"}, {31'd0, ReqReady}, 32'd0);
        end
        e = exp_q.pop_front();
        check({tag, "_latency"}, lat, {28'd0, e.lat});
        snap = RspResult;
        for (int i = 0; i < hold; i++) begin
            @(posedge Clock);
            #1;
            check({tag, "_hold_valid"}, {31'd0, RspValid}, 32'd1);
            check({tag, "_hold_ready"}, {31'd0, ReqReady}, 32'd0);
            check({tag, "_hold_result"}, RspResult, snap);
        end
        check({tag, "_result"}, RspResult, e.res);
        check({tag, "_zero"}, {31'd0, RspZero}, {31'd0, e.zero});
        check({tag, "_ovf"}, {31'd0, RspOverflow}, {31'd0, e.ovf});
        check({tag, "_carry"}, {31'd0, RspCarry}, {31'd0, e.carry});
        RspReady = 1'b1;
        @(posedge Clock);
        #1;
        RspReady = 1'b0;
        check({tag, "_post_valid"}, {31'd0, RspValid}, 32'd0);
        check({tag, "_post_ready"}, {31'd0, ReqReady}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [2:0] op_tbl [8];
    bit         ok_r;

    initial begin
        op_tbl = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};
        Reset_n  = 1'b0;
        ReqValid = 1'b0;
        ReqOp    = 3'b000;
        ReqWide  = 1'b0;
        ReqA     = 32'h0;
        ReqB     = 32'h0;
        RspReady = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check("rst_req_ready", {31'd0, ReqReady}, 32'd1);
        check("rst_rsp_valid", {31'd0, RspValid}, 32'd0);
        check("rst_rsp_result", RspResult, 32'd0);
        check("rst_rsp_flags", {29'd0, RspZero, RspOverflow, RspCarry}, 32'd0);
        check("rst_alu", {AluA, AluB}, 32'd0);
        check("rst_alu_ctl", {29'd0, AluBNegate, AluOp}, 32'd0);
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;

        run_req("n_add_ovf", 3'b010, 1'b0, 32'h0000_7FFF, 32'h0000_0001, 0);
        run_req("n_slt", 3'b111, 1'b0, 32'h0000_FFFF, 32'h0000_0001, 1);
        run_req("w_add_fix", 3'b010, 1'b1, 32'h0000_FFFF, 32'h0000_0001, 0);
        run_req("w_sub_fix", 3'b110, 1'b1, 32'h0001_0000, 32'h0000_0001, 0);
        run_req("w_sub_eq", 3'b110, 1'b1, 32'h1234_5678, 32'h1234_5678, 0);
        run_req("w_add_ovf", 3'b010, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 5);
        run_req("w_and", 3'b000, 1'b1, 32'hF0F0_1234, 32'hFF00_00FF, 0);
        run_req("w_or", 3'b001, 1'b1, 32'hF0F0_1234, 32'h0F00_0000, 0);
        run_req("n_sub", 3'b110, 1'b0, 32'h0000_0003, 32'h0000_0005, 0);
        run_req("slt_wide", 3'b111, 1'b1, 32'h0000_0005, 32'h0000_8000, 0);
        run_req("op_other", 3'b011, 1'b1, 32'hAAAA_5555, 32'h0F0F_FFFF, 0);
        run_req("n_hiignore", 3'b010, 1'b0, 32'hFFFF_0001, 32'hFFFF_0002, 0);

        // Reset while the controller is in the upper-half pass.
        accept_req(3'b010, 1'b1, 32'hABCD_0001, 32'h1234_FFFF, ok_r);
        @(posedge Clock);
        #2;
        check("pre_rst_alu_a", {16'd0, AluA}, 32'h0000_ABCD);
        Reset_n = 1'b0;
        #1;
        void'(exp_q.pop_front());
        check("mid_rst_req_ready", {31'd0, ReqReady}, 32'd1);
        check("mid_rst_rsp_valid", {31'd0, RspValid}, 32'd0);
        check("mid_rst_alu", {AluA, AluB}, 32'd0);
        check("mid_rst_alu_ctl", {29'd0, AluBNegate, AluOp}, 32'd0);
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;
        run_req("after_rst", 3'b110, 1'b1, 32'h8000_0000, 32'h0000_0001, 0);

        for (int i = 0; i < 24; i++) begin
            run_req("rand", op_tbl[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
                    $urandom, $urandom, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
